// File: rtl/reg_port_sched_if.sv
// Bundle of core, swap-request and register-file signals around reg_port_sched.
// master: core/decode side plus register-file read data; slave: the scheduler.
interface reg_port_sched_if #(
    parameter int unsigned pw = 4
);
    logic          wb_en;
    logic [pw:0]   wb_addr;
    logic [7:0]    wb_dat;
    logic [pw:0]   core_rd_addrA;
    logic [pw:0]   core_rd_addrB;
    logic          swap_req;
    logic [pw:0]   swap_addrA;
    logic [pw:0]   swap_addrB;
    logic          swap_ack;
    logic          swap_done;
    logic          busy;
    logic [7:0]    rf_datA;
    logic [7:0]    rf_datB;
    logic          rf_wr_en;
    logic [pw:0]   rf_wr_addr;
    logic [7:0]    rf_dat_in;
    logic [pw:0]   rf_rd_addrA;
    logic [pw:0]   rf_rd_addrB;
    logic          rf_do_swap;

    modport master (
        output wb_en, wb_addr, wb_dat, core_rd_addrA, core_rd_addrB,
        output swap_req, swap_addrA, swap_addrB, rf_datA, rf_datB,
        input  swap_ack, swap_done, busy, rf_wr_en, rf_wr_addr, rf_dat_in,
        input  rf_rd_addrA, rf_rd_addrB, rf_do_swap
    );

    modport slave (
        input  wb_en, wb_addr, wb_dat, core_rd_addrA, core_rd_addrB,
        input  swap_req, swap_addrA, swap_addrB, rf_datA, rf_datB,
        output swap_ack, swap_done, busy, rf_wr_en, rf_wr_addr, rf_dat_in,
        output rf_rd_addrA, rf_rd_addrB, rf_do_swap
    );
endinterface

// File: rtl/reg_port_sched.sv
// Register-file port scheduler: post-reset clear, writeback priority, and
// register swap built from a read capture plus two ordinary port writes.
module reg_port_sched #(
    parameter int unsigned pw = 4
) (
    input logic              i_clk,
    input logic              i_reset_n,
    reg_port_sched_if.slave  if_bus
);
    localparam int unsigned AW = pw + 1;

    typedef enum logic [2:0] {StInit, StIdle, StCap, StWrA, StWrB} state_e;

    state_e        r_state, w_state_nxt;
    logic [pw-1:0] r_cnt, w_cnt_nxt;
    logic [AW-1:0] r_addr_a, w_addr_a_nxt;
    logic [AW-1:0] r_addr_b, w_addr_b_nxt;
    logic [7:0]    r_cap_a, w_cap_a_nxt;
    logic [7:0]    r_cap_b, w_cap_b_nxt;
    logic          r_pend_a, w_pend_a_nxt;
    logic          r_pend_b, w_pend_b_nxt;
    // Self-swap completes one cycle after CAP, while already back in IDLE.
    logic          r_self_done, w_self_done_nxt;

    logic          w_wb_act;
    logic          w_hit_a;
    logic          w_hit_b;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [7:0]    w_wr_dat;
    logic [AW-1:0] w_rd_addr_a;
    logic [AW-1:0] w_rd_addr_b;
    logic          w_ack;
    logic          w_done;
    logic          w_busy;

    assign w_wb_act = if_bus.wb_en && (r_state != StInit) && i_reset_n;
    assign w_hit_a  = w_wb_act && (if_bus.wb_addr == r_addr_a);
    assign w_hit_b  = w_wb_act && (if_bus.wb_addr == r_addr_b);

    // Next-state logic, write-port arbitration and read-pointer mux.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_addr_a_nxt    = r_addr_a;
        w_addr_b_nxt    = r_addr_b;
        w_cap_a_nxt     = r_cap_a;
        w_cap_b_nxt     = r_cap_b;
        w_pend_a_nxt    = r_pend_a;
        w_pend_b_nxt    = r_pend_b;
        w_self_done_nxt = 1'b0;
        w_wr_en         = 1'b0;
        w_wr_addr       = '0;
        w_wr_dat        = '0;
        w_rd_addr_a     = if_bus.core_rd_addrA;
        w_rd_addr_b     = if_bus.core_rd_addrB;
        w_ack           = 1'b0;
        w_done          = r_self_done;
        w_busy          = (r_state != StIdle);

        // Writeback always owns the port outside INIT.
        if (w_wb_act) begin
            w_wr_en   = 1'b1;
            w_wr_addr = if_bus.wb_addr;
            w_wr_dat  = if_bus.wb_dat;
        end

        unique case (r_state)
            StInit: begin
                w_wr_en   = 1'b1;
                w_wr_addr = {1'b0, r_cnt};
                w_wr_dat  = 8'h00;
                w_cnt_nxt = r_cnt + pw'(1);
                if (r_cnt == '1) begin
                    w_state_nxt = StIdle;
                end
            end
            StIdle: begin
                if (if_bus.swap_req) begin
                    w_ack        = 1'b1;
                    w_addr_a_nxt = if_bus.swap_addrA;
                    w_addr_b_nxt = if_bus.swap_addrB;
                    w_state_nxt  = StCap;
                end
            end
            StCap: begin
                w_rd_addr_a  = r_addr_a;
                w_rd_addr_b  = r_addr_b;
                w_cap_a_nxt  = if_bus.rf_datA;
                w_cap_b_nxt  = if_bus.rf_datB;
                // A writeback in this cycle lands after the capture, so it wins.
                w_pend_a_nxt = !w_hit_a;
                w_pend_b_nxt = !w_hit_b;
                if (r_addr_a == r_addr_b) begin
                    w_self_done_nxt = 1'b1;
                    w_state_nxt     = StIdle;
                end else begin
                    w_state_nxt = StWrA;
                end
            end
            StWrA: begin
                if (w_wb_act) begin
                    if (w_hit_a) w_pend_a_nxt = 1'b0;
                    if (w_hit_b) w_pend_b_nxt = 1'b0;
                end else begin
                    if (r_pend_a) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_addr_a;
                        w_wr_dat  = r_cap_b;
                    end
                    w_state_nxt = StWrB;
                end
            end
            StWrB: begin
                if (w_wb_act) begin
                    if (w_hit_b) w_pend_b_nxt = 1'b0;
                end else begin
                    if (r_pend_b) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_addr_b;
                        w_wr_dat  = r_cap_a;
                    end
                    w_done      = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StInit;
        endcase

        // Hold the port quiet while reset is asserted so an abandoned swap never writes.
        if (!i_reset_n) begin
            w_wr_en = 1'b0;
            w_ack   = 1'b0;
            w_done  = 1'b0;
            w_busy  = 1'b1;
        end
    end

    // State and swap-context registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= StInit;
            r_cnt       <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_cap_a     <= '0;
            r_cap_b     <= '0;
            r_pend_a    <= 1'b0;
            r_pend_b    <= 1'b0;
            r_self_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr_a    <= w_addr_a_nxt;
            r_addr_b    <= w_addr_b_nxt;
            r_cap_a     <= w_cap_a_nxt;
            r_cap_b     <= w_cap_b_nxt;
            r_pend_a    <= w_pend_a_nxt;
            r_pend_b    <= w_pend_b_nxt;
            r_self_done <= w_self_done_nxt;
        end
    end

    assign if_bus.rf_wr_en    = w_wr_en;
    assign if_bus.rf_wr_addr  = w_wr_addr;
    assign if_bus.rf_dat_in   = w_wr_dat;
    assign if_bus.rf_rd_addrA = w_rd_addr_a;
    assign if_bus.rf_rd_addrB = w_rd_addr_b;
    assign if_bus.swap_ack    = w_ack;
    assign if_bus.swap_done   = w_done;
    assign if_bus.busy        = w_busy;
    assign if_bus.rf_do_swap  = 1'b0;
endmodule

// File: tb/tb_reg_port_sched.sv
// Scoreboard bench for reg_port_sched: expected port writes and done pulses are
// queued by the stimulus, a negedge monitor pops and compares them.
module tb_reg_port_sched;
    localparam int unsigned PW = 4;

    typedef struct packed {
        logic       kind;  // 0 = write, 1 = swap_done
        logic [4:0] addr;
        logic [7:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    logic [7:0] mem [32];

    reg_port_sched_if #(.pw(PW)) bus ();

    reg_port_sched #(.pw(PW)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .if_bus    (bus)
    );

    always #5 clk = ~clk;

    // Register-file model: combinational reads, write on rising edge.
    assign bus.rf_datA = mem[bus.rf_rd_addrA];
    assign bus.rf_datB = mem[bus.rf_rd_addrB];
    always @(posedge clk) begin
        if (bus.rf_wr_en === 1'b1) mem[bus.rf_wr_addr] <= bus.rf_dat_in;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sb_pop(input string nm, input exp_t act);
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got kind=%0d addr=%0h dat=%0h expected nothing",
                     nm, act.kind, act.addr, act.dat);
        end else begin
            e = q.pop_front();
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got kind=%0d addr=%0h dat=%0h expected kind=%0d addr=%0h dat=%0h",
                         nm, act.kind, act.addr, act.dat, e.kind, e.addr, e.dat);
            end
        end
    endtask

    // Monitor: each write and each done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (bus.rf_wr_en === 1'b1) sb_pop("rf_write", {1'b0, bus.rf_wr_addr, bus.rf_dat_in});
        if (bus.swap_done === 1'b1) sb_pop("swap_done", {1'b1, 5'd0, 8'h00});
    end

    task automatic exp_wr(input logic [4:0] a, input logic [7:0] d);
        q.push_back({1'b0, a, d});
    endtask

    task automatic exp_done();
        q.push_back({1'b1, 5'd0, 8'h00});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [7:0] d);
        exp_wr(a, d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = a;
        bus.wb_dat  = d;
        tick();
        bus.wb_en   = 1'b0;
    endtask

    // Issue a swap; wb_mask bit i drives a writeback of (wa, wd) in cycle i after ack.
    task automatic do_swap(input string nm, input logic [4:0] a, input logic [4:0] b,
                           input logic [31:0] wb_mask, input logic [4:0] wa,
                           input logic [7:0] wd, input int exp_cyc);
        int got = -1;
        bus.swap_req   = 1'b1;
        bus.swap_addrA = a;
        bus.swap_addrB = b;
        for (int i = 0; i < 24 && got < 0; i++) begin
            bus.wb_en   = wb_mask[i];
            bus.wb_addr = wa;
            bus.wb_dat  = wd;
            @(negedge clk);
            if (i == 0) begin
                chk({nm, "_ack"}, 32'(bus.swap_ack), 32'd1);
            end
            if (i == 1) begin
                chk({nm, "_cap_rdA"}, 32'(bus.rf_rd_addrA), 32'(a));
                chk({nm, "_cap_rdB"}, 32'(bus.rf_rd_addrB), 32'(b));
                chk({nm, "_cap_busy"}, 32'(bus.busy), 32'd1);
            end
            if (bus.swap_done === 1'b1) got = i;
            tick();
            if (i == 0) bus.swap_req = 1'b0;
        end
        bus.wb_en = 1'b0;
        chk({nm, "_done_cycle"}, 32'(got), 32'(exp_cyc));
        @(negedge clk);
        chk({nm, "_busy_after"}, 32'(bus.busy), 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        bus.wb_en         = 1'b0;
        bus.wb_addr       = '0;
        bus.wb_dat        = '0;
        bus.core_rd_addrA = 5'd12;
        bus.core_rd_addrB = 5'd13;
        bus.swap_req      = 1'b0;
        bus.swap_addrA    = '0;
        bus.swap_addrB    = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("rst_ack", 32'(bus.swap_ack), 32'd0);
        chk("rst_done", 32'(bus.swap_done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_do_swap", 32'(bus.rf_do_swap), 32'd0);

        // Post-reset clear: 16 writes of zero, writeback ignored meanwhile.
        for (int i = 0; i < 16; i++) exp_wr(5'(i), 8'h00);
        tick();
        reset_n = 1'b1;
        tick();
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd20;
        bus.wb_dat  = 8'hEE;
        tick();
        bus.wb_en   = 1'b0;
        repeat (13) tick();
        @(negedge clk);
        chk("init_last_busy", 32'(bus.busy), 32'd1);
        tick();
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_rdA", 32'(bus.rf_rd_addrA), 32'd12);
        chk("idle_rdB", 32'(bus.rf_rd_addrB), 32'd13);
        chk("init_clr_r20", 32'(mem[20]), 32'(mem[20] === 8'hEE ? 8'h00 : mem[20]));
        tick();

        // Basic swap.
        wb_write(5'd3, 8'h5A);
        wb_write(5'd7, 8'hC3);
        exp_wr(5'd3, 8'hC3);
        exp_wr(5'd7, 8'h5A);
        exp_done();
        do_swap("basic", 5'd3, 5'd7, 32'h0, 5'd0, 8'h00, 3);
        chk("basic_r3", 32'(mem[3]), 32'h C3);
        chk("basic_r7", 32'(mem[7]), 32'h5A);

        // Self swap: no writes, done one cycle after CAP.
        wb_write(5'd5, 8'h11);
        exp_done();
        do_swap("self", 5'd5, 5'd5, 32'h0, 5'd0, 8'h00, 2);
        chk("self_r5", 32'(mem[5]), 32'h11);

        // Port conflict: writeback in one WR_A and one WR_B cycle.
        exp_wr(5'd9, 8'h22);
        exp_wr(5'd3, 8'h5A);
        exp_wr(5'd9, 8'h22);
        exp_wr(5'd7, 8'hC3);
        exp_done();
        do_swap("conflict", 5'd3, 5'd7, 32'h14, 5'd9, 8'h22, 5);
        chk("conflict_r3", 32'(mem[3]), 32'h5A);
        chk("conflict_r7", 32'(mem[7]), 32'hC3);
        chk("conflict_r9", 32'(mem[9]), 32'h22);

        // Hazard in WR_A: writeback to operand A wins, B still gets old A.
        exp_wr(5'd3, 8'h77);
        exp_wr(5'd7, 8'h5A);
        exp_done();
        do_swap("hazard_wra", 5'd3, 5'd7, 32'h4, 5'd3, 8'h77, 4);
        chk("hazard_r3", 32'(mem[3]), 32'h77);
        chk("hazard_r7", 32'(mem[7]), 32'h5A);

        // Hazard in CAP: writeback to operand B is ordered after the capture.
        exp_wr(5'd7, 8'h99);
        exp_wr(5'd3, 8'h5A);
        exp_done();
        do_swap("hazard_cap", 5'd3, 5'd7, 32'h2, 5'd7, 8'h99, 3);
        chk("hcap_r3", 32'(mem[3]), 32'h5A);
        chk("hcap_r7", 32'(mem[7]), 32'h99);

        // Writeback in the ack cycle: swap sees its result.
        exp_wr(5'd3, 8'h44);
        exp_wr(5'd3, 8'h99);
        exp_wr(5'd7, 8'h44);
        exp_done();
        do_swap("wb_ack", 5'd3, 5'd7, 32'h1, 5'd3, 8'h44, 3);
        chk("wback_r3", 32'(mem[3]), 32'h99);
        chk("wback_r7", 32'(mem[7]), 32'h44);

        // Reset during WR_A: no swap write, no done, clear restarts at 0.
        bus.swap_req   = 1'b1;
        bus.swap_addrA = 5'd3;
        bus.swap_addrB = 5'd7;
        @(negedge clk);
        chk("rstswap_ack", 32'(bus.swap_ack), 32'd1);
        tick();
        bus.swap_req = 1'b0;
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstswap_wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("rstswap_done", 32'(bus.swap_done), 32'd0);
        for (int i = 0; i < 16; i++) exp_wr(5'(i), 8'h00);
        tick();
        reset_n = 1'b1;
        repeat (15) tick();
        @(negedge clk);
        chk("rstswap_init_busy", 32'(bus.busy), 32'd1);
        tick();
        @(negedge clk);
        chk("rstswap_idle_busy", 32'(bus.busy), 32'd0);
        chk("rstswap_r3", 32'(mem[3]), 32'h00);
        chk("rstswap_r7", 32'(mem[7]), 32'h00);
        repeat (3) tick();
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_port_sched.md
Name: reg_port_sched

Overview:
- Scheduler for the single write port and the two combinational read ports of the 8-bit register file (parameter pw; 2**pw entries).
- Arbitrates between two write sources:
  - core ALU/load writeback, which has highest priority and never stalls;
  - a register-swap request, executed as read-capture plus two sequential port writes. The file's in-place swap path is never used.
- Also runs a post-reset clear of every register.
- Sits between the decode/writeback stage and reg_file.

Parameters:
- pw, 4, register address pointer width. Address buses are pw+1 bits; the file depth is 2**pw.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- wb_en  in  1  core writeback request, single cycle
- wb_addr  in  pw+1  writeback destination
- wb_dat  in  8  writeback data
- core_rd_addrA  in  pw+1  core read pointer A
- core_rd_addrB  in  pw+1  core read pointer B
- swap_req  in  1  swap request; held high until swap_ack
- swap_addrA  in  pw+1  swap operand A; stable while swap_req is high
- swap_addrB  in  pw+1  swap operand B; stable while swap_req is high
- swap_ack  out  1  one-cycle accept pulse
- swap_done  out  1  one-cycle completion pulse
- busy  out  1  stall to fetch/decode; core must not issue reads
- rf_datA  in  8  register-file read data A
- rf_datB  in  8  register-file read data B
- rf_wr_en  out  1  register-file write enable
- rf_wr_addr  out  pw+1  register-file write address
- rf_dat_in  out  8  register-file write data
- rf_rd_addrA  out  pw+1  register-file read pointer A
- rf_rd_addrB  out  pw+1  register-file read pointer B
- rf_do_swap  out  1  constant 0

Behaviour:
- Reset: one clock, synchronous, active-low (reset_n low on a clk rising edge).
  - Reset values: state=INIT, clear counter=0. swap_ack, swap_done, rf_wr_en and rf_do_swap all 0; busy=1.
  - Captured operands and pending flags are cleared.
  - Reset mid-swap abandons the swap with no further writes and no done pulse, then re-enters INIT.
- FSM states: INIT, IDLE, CAP, WR_A, WR_B.
- INIT:
  - Writes 0 to address cnt each cycle, cnt from 0 to 2**pw-1; exactly 2**pw cycles. Then goes to IDLE.
  - wb_en is ignored and swap_req is not acked while in INIT.
- Read mux:
  - In CAP, rf_rd_addrA/B = swap_addrA/B.
  - In all other states, rf_rd_addrA/B = core_rd_addrA/B, combinationally.
- Write port priority when not in INIT:
  - wb_en=1 gives rf_wr_en=1, rf_wr_addr=wb_addr, rf_dat_in=wb_dat in the same cycle, in any state.
  - The swap engine writes only in cycles with wb_en=0.
- IDLE:
  - swap_req=1 gives swap_ack=1 that cycle and moves to CAP next cycle.
  - A swap accepted in the same cycle as a wb_en write: the swap is ordered after that write and captures its result in CAP.
- CAP (1 cycle):
  - Latch capA=rf_datA and capB=rf_datB.
  - Set pendA and pendB.
  - If swap_addrA==swap_addrB, go to IDLE with swap_done=1 next cycle and make no writes. Otherwise go to WR_A.
  - A wb_en write in the CAP cycle is ordered after the swap: it clears the pending flag of a matching operand before that flag is set.
- WR_A:
  - If wb_en=0 and pendA: write addrA<=capB and go to WR_B.
  - If wb_en=0 and !pendA: go to WR_B without writing.
  - If wb_en=1: stay in WR_A.
- WR_B: same rule as WR_A for addrB<=capA. On completion, swap_done=1 in the cycle the final write issues (or the skip cycle), then go to IDLE.
- Hazard rule: a wb_en write in CAP, WR_A or WR_B whose wb_addr matches a still-pending swap operand clears that pend flag, so writeback data wins. Captured values are not updated, so the other operand still receives the old value.
- busy = 1 in INIT, CAP, WR_A and WR_B; 0 in IDLE.
- Latency with no conflicts: ack in cycle 0, CAP in cycle 1, WR_A in cycle 2, WR_B plus swap_done in cycle 3, busy low in cycle 4. Each wb collision adds one cycle.
- swap_req is not re-acked until the FSM has returned to IDLE.

Test Plan:
- Reset then idle (pw=4): release reset_n → rf_wr_en high for exactly 16 cycles, addresses 0..15, data 0x00, then busy=0.
- Basic swap: R3=0x5A and R7=0xC3 via wb; swap_req with A=3, B=7 → ack cycle 0, done cycle 3, then R3=0xC3 and R7=0x5A.
- Self swap: A=B=5, R5=0x11 → done one cycle after CAP, no rf_wr_en pulses, R5=0x11.
- Port conflict: wb_en held on R9=0x22 during the WR_A and WR_B cycles → swap writes deferred, done delayed by 2 cycles, final values correct, R9=0x22.
- Hazard: in WR_A, wb writes R3=0x77 → R3 remains 0x77 and R7 gets the old R3 value 0x5A.
- Reset during WR_A → no write to R7, no swap_done, INIT clear restarts from address 0.
